// File: rtl/mem_wb_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_seq_if
//  Description : Data-memory request/acknowledge bus between the MEM/WB
//                sequencer (master) and the data memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_wb_seq_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_seq
//  Description : Multicycle MEM/WB sequencer. Latches one decoded control
//                word plus operands, performs the data-memory access over a
//                req/ack bus, then does register writeback and the branch
//                decision. Optional MEM_WAIT timeout enabled by defining
//                MEMSEQ_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_seq #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              in_valid,
  output logic                   in_ready,
  input  wire logic              RegDist,
  input  wire logic              Branch,
  input  wire logic              MemRead,
  input  wire logic              Memtoreg,
  input  wire logic              MemWrite,
  input  wire logic              Regwrite,
  input  wire logic [DATA_W-1:0] alu_result,
  input  wire logic [DATA_W-1:0] store_data,
  input  wire logic              alu_zero,
  input  wire logic [REG_AW-1:0] rt_addr,
  input  wire logic [REG_AW-1:0] rd_addr,
  mem_wb_seq_if.master           mem,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   pc_src,
  output logic                   mem_err
);

  // A zero timeout would abort every access before the memory could answer.
  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_wb_seq: MEM_TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_WB       = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                regdist_q, regdist_d;
  logic                branch_q, branch_d;
  logic                memtoreg_q, memtoreg_d;
  logic                memwrite_q, memwrite_d;
  logic                regwrite_q, regwrite_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic [REG_AW-1:0]   rt_q, rt_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  // kill suppresses the architectural effects of WB (illegal word / timeout)
  logic                kill_q, kill_d;
  logic                err_q, err_d;

`ifdef MEMSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Next-state and latch-enable logic for the sequencer
  always_comb begin
    state_d    = state_q;
    regdist_d  = regdist_q;
    branch_d   = branch_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    regwrite_d = regwrite_q;
    zero_d     = zero_q;
    alu_d      = alu_q;
    store_d    = store_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    kill_d     = kill_q;
    err_d      = err_q;
`ifdef MEMSEQ_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          regdist_d  = RegDist;
          branch_d   = Branch;
          memtoreg_d = Memtoreg;
          memwrite_d = MemWrite;
          regwrite_d = Regwrite;
          zero_d     = alu_zero;
          alu_d      = alu_result;
          store_d    = store_data;
          rt_d       = rt_addr;
          rd_d       = rd_addr;
          // Cleared so a Memtoreg op without an access never sees stale data
          rdata_d    = '0;
          kill_d     = MemRead & MemWrite;
          if (MemRead & MemWrite) err_d = 1'b1;
          state_d    = (MemRead ^ MemWrite) ? S_MEM_WAIT : S_WB;
`ifdef MEMSEQ_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      S_MEM_WAIT: begin
        // An ack always wins, even in the cycle the timeout would fire
        if (mem.mem_ack) begin
          rdata_d = mem.mem_rdata;
          state_d = S_WB;
        end
`ifdef MEMSEQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          kill_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched operand registers; reset drops any open transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      regdist_q  <= 1'b0;
      branch_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
      zero_q     <= 1'b0;
      alu_q      <= '0;
      store_q    <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      regdist_q  <= regdist_d;
      branch_q   <= branch_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      regwrite_q <= regwrite_d;
      zero_q     <= zero_d;
      alu_q      <= alu_d;
      store_q    <= store_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
`ifdef MEMSEQ_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  logic              in_wb;
  logic              in_mem;
  logic [REG_AW-1:0] waddr_sel;

  // Outputs decoded only from state and latched registers (no in_* paths)
  always_comb begin
    in_wb         = (state_q == S_WB);
    in_mem        = (state_q == S_MEM_WAIT);
    waddr_sel     = regdist_q ? rd_q : rt_q;
    in_ready      = (state_q == S_IDLE);
    mem.mem_req   = in_mem;
    mem.mem_we    = in_mem & memwrite_q;
    mem.mem_addr  = in_mem ? alu_q   : '0;
    mem.mem_wdata = in_mem ? store_q : '0;
    rf_waddr      = in_wb ? waddr_sel : '0;
    rf_wdata      = in_wb ? (memtoreg_q ? rdata_q : alu_q) : '0;
    rf_we         = in_wb & regwrite_q & ~kill_q & (waddr_sel != '0);
    pc_src        = in_wb & branch_q & zero_q & ~kill_q;
    mem_err       = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_seq
//  Description : Directed self-checking bench for mem_wb_seq. Define
//                MEMSEQ_TIMEOUT_EN for both files to cover the timeout path.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_wb_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  wire  logic  in_ready;
  logic        RegDist = 0, Branch = 0, MemRead = 0, Memtoreg = 0;
  logic        MemWrite = 0, Regwrite = 0, alu_zero = 0;
  logic [31:0] alu_result = '0, store_data = '0;
  logic [4:0]  rt_addr = '0, rd_addr = '0;
  wire  logic        rf_we;
  wire  logic [4:0]  rf_waddr;
  wire  logic [31:0] rf_wdata;
  wire  logic        pc_src;
  wire  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_seq_if #(.DATA_W(32)) mem_bus ();

  mem_wb_seq #(.DATA_W(32), .REG_AW(5), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .RegDist(RegDist), .Branch(Branch), .MemRead(MemRead),
    .Memtoreg(Memtoreg), .MemWrite(MemWrite), .Regwrite(Regwrite),
    .alu_result(alu_result), .store_data(store_data), .alu_zero(alu_zero),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .mem(mem_bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_src(pc_src), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one accept edge; returns 1 ns after that edge
  task automatic issue(input logic rd_sel, br, mr, m2r, mw, rw, z,
                       input logic [31:0] alu, sd, input logic [4:0] rt, rd);
    RegDist = rd_sel; Branch = br; MemRead = mr; Memtoreg = m2r;
    MemWrite = mw; Regwrite = rw; alu_zero = z; alu_result = alu;
    store_data = sd; rt_addr = rt; rd_addr = rd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %b required 0", mem_bus.mem_req); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL reset_mem_err got %b required 0", mem_err); end
    n_cmp++; if ({rf_we, pc_src, rf_waddr, rf_wdata} !== '0) begin n_bad++; $display("FAIL reset_wb_outs got %h required 0", {rf_we, pc_src, rf_waddr, rf_wdata}); end
  endtask

  task automatic test_rtype();
    issue(1, 0, 0, 0, 0, 1, 0, 32'h1234, 32'h0, 5'd3, 5'd9);
    n_cmp++; if (rf_we !== 1'b1) begin n_bad++; $display("FAIL rtype_rf_we got %b required 1", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd9) begin n_bad++; $display("FAIL rtype_waddr got %0d required 9", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'h1234) begin n_bad++; $display("FAIL rtype_wdata got %h required 00001234", rf_wdata); end
    n_cmp++; if (mem_bus.mem_req !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rtype_req_ready got %b%b required 00", mem_bus.mem_req, in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1 || rf_we !== 1'b0) begin n_bad++; $display("FAIL rtype_back_idle got ready=%b we=%b required ready=1 we=0", in_ready, rf_we); end
  endtask

  task automatic test_load();
    int req_cycles = 0;
    // An ack seen while IDLE must not complete the upcoming access
    mem_bus.mem_ack = 1'b1;
    issue(0, 0, 1, 1, 0, 1, 0, 32'h40, 32'h0, 5'd4, 5'd7);
    mem_bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_bus.mem_req === 1'b1) req_cycles++;
      n_cmp++; if (mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== 32'h40) begin n_bad++; $display("FAIL load_bus got we=%b addr=%h required we=0 addr=00000040", mem_bus.mem_we, mem_bus.mem_addr); end
      if (i == 2) begin mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEADBEEF; end
      tick();
    end
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    n_cmp++; if (req_cycles != 3) begin n_bad++; $display("FAIL load_req_cycles got %0d required 3", req_cycles); end
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4) begin n_bad++; $display("FAIL load_wb got we=%b waddr=%0d required we=1 waddr=4", rf_we, rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_wdata got %h required deadbeef", rf_wdata); end
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL load_req_drop got %b required 0", mem_bus.mem_req); end
    tick();
  endtask

  task automatic test_store();
    issue(0, 0, 0, 0, 1, 0, 0, 32'h80, 32'hA5A5, 5'd2, 5'd3);
    n_cmp++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL store_req_we got %b%b required 11", mem_bus.mem_req, mem_bus.mem_we); end
    n_cmp++; if (mem_bus.mem_addr !== 32'h80 || mem_bus.mem_wdata !== 32'hA5A5) begin n_bad++; $display("FAIL store_addr_data got %h/%h required 00000080/0000a5a5", mem_bus.mem_addr, mem_bus.mem_wdata); end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    n_cmp++; if (rf_we !== 1'b0 || mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL store_wb got we=%b req=%b required 0 0", rf_we, mem_bus.mem_req); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL store_occupancy got ready=%b required 1", in_ready); end
    issue(1, 0, 0, 0, 0, 1, 0, 32'h55, 32'h0, 5'd6, 5'd0);
    n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin n_bad++; $display("FAIL r0_write got we=%b waddr=%0d required we=0 waddr=0", rf_we, rf_waddr); end
    tick();
  endtask

  task automatic test_branch();
    issue(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 5'd0, 5'd0);
    n_cmp++; if (pc_src !== 1'b1) begin n_bad++; $display("FAIL branch_taken got %b required 1", pc_src); end
    tick();
    n_cmp++; if (pc_src !== 1'b0) begin n_bad++; $display("FAIL branch_pulse_len got %b required 0", pc_src); end
    issue(0, 1, 0, 0, 0, 0, 0, 32'h1, 32'h0, 5'd0, 5'd0);
    n_cmp++; if (pc_src !== 1'b0) begin n_bad++; $display("FAIL branch_not_taken got %b required 0", pc_src); end
    tick();
  endtask

  task automatic test_back_to_back();
    RegDist = 1; Branch = 0; MemRead = 0; Memtoreg = 0; MemWrite = 0;
    Regwrite = 1; alu_zero = 0; alu_result = 32'h1111; rd_addr = 5'd10;
    in_valid = 1'b1;
    tick();
    n_cmp++; if (rf_wdata !== 32'h1111 || in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_first got wdata=%h ready=%b required 00001111 0", rf_wdata, in_ready); end
    alu_result = 32'h2222; rd_addr = 5'd11;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || rf_we !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got ready=%b we=%b required 1 0", in_ready, rf_we); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'h2222) begin n_bad++; $display("FAIL b2b_second got we=%b waddr=%0d wdata=%h required 1 11 00002222", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask

`ifdef MEMSEQ_TIMEOUT_EN
  task automatic test_timeout();
    int held = 0;
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_before got %b required 0", mem_err); end
    issue(0, 0, 1, 1, 0, 1, 0, 32'h100, 32'h0, 5'd7, 5'd0);
    while (mem_bus.mem_req === 1'b1 && held < 40) begin
      held++;
      tick();
    end
    n_cmp++; if (held != 15) begin n_bad++; $display("FAIL timeout_req_cycles got %0d required 15", held); end
    n_cmp++; if (rf_we !== 1'b0 || pc_src !== 1'b0) begin n_bad++; $display("FAIL timeout_wb got we=%b pc=%b required 0 0", rf_we, pc_src); end
    n_cmp++; if (mem_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got %b required 1", mem_err); end
    tick();
  endtask
`else
  task automatic test_long_wait();
    int held = 0;
    issue(0, 0, 1, 1, 0, 1, 0, 32'h100, 32'h0, 5'd6, 5'd0);
    for (int i = 0; i < 20; i++) begin
      if (mem_bus.mem_req === 1'b1) held++;
      tick();
    end
    n_cmp++; if (held != 20) begin n_bad++; $display("FAIL long_wait_held got %0d required 20", held); end
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0BADF00D;
    tick();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    n_cmp++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL long_wait_wb got we=%b wdata=%h required 1 0badf00d", rf_we, rf_wdata); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL long_wait_err got %b required 0", mem_err); end
    tick();
  endtask
`endif

  task automatic test_illegal();
    issue(1, 1, 1, 0, 1, 1, 1, 32'h10, 32'h20, 5'd1, 5'd5);
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL illegal_req got %b required 0", mem_bus.mem_req); end
    n_cmp++; if (mem_err !== 1'b1) begin n_bad++; $display("FAIL illegal_err got %b required 1", mem_err); end
    n_cmp++; if (rf_we !== 1'b0 || pc_src !== 1'b0) begin n_bad++; $display("FAIL illegal_wb got we=%b pc=%b required 0 0", rf_we, pc_src); end
    tick();
    issue(1, 0, 0, 0, 0, 1, 0, 32'h77, 32'h0, 5'd0, 5'd12);
    n_cmp++; if (rf_we !== 1'b1 || mem_err !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky got we=%b err=%b required 1 1", rf_we, mem_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(0, 0, 1, 0, 0, 1, 0, 32'h200, 32'h0, 5'd8, 5'd0);
    n_cmp++; if (mem_bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req_before got %b required 1", mem_bus.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_bus.mem_req !== 1'b0 || mem_err !== 1'b0) begin n_bad++; $display("FAIL rmid_async got req=%b err=%b required 0 0", mem_bus.mem_req, mem_err); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got %b required 1", in_ready); end
    n_cmp++; if ({mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata} !== '0) begin n_bad++; $display("FAIL rmid_bus got %h required 0", {mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}); end
    n_cmp++; if ({rf_we, pc_src, mem_err, rf_waddr, rf_wdata} !== '0) begin n_bad++; $display("FAIL rmid_outs got %h required 0", {rf_we, pc_src, mem_err, rf_waddr, rf_wdata}); end
    tick();
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_no_replay got %b required 0", mem_bus.mem_req); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
`ifdef MEMSEQ_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
